// File: rtl/pipe_result_collector.sv
// ============================================================================
// Module   : pipe_result_collector
// Purpose  : Packs SUM_W-bit adder beats, LSB nibble first, into one word of
//            NIBBLES*SUM_W bits. The result is held in an output register with
//            a valid/ready handshake.
//            Optional macro: COLLECT_PARITY_EN adds the out_parity port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_result_collector #(
    parameter int SUM_W   = 4,
    parameter int NIBBLES = 4,
    parameter int CNT_W   = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SUM_W-1:0]         in_sum,
    input  logic                     in_carry,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NIBBLES*SUM_W-1:0] out_data,
    output logic                     out_carry,
    output logic [CNT_W-1:0]         out_count,
    output logic                     out_short
`ifdef COLLECT_PARITY_EN
    ,
    output logic                     out_parity
`endif
);

    localparam int         c_data_w   = NIBBLES * SUM_W;
    localparam logic [0:0] c_st_empty = 1'b0;
    localparam logic [0:0] c_st_full  = 1'b1;

    logic [0:0]          r_state;
    logic [CNT_W-1:0]    r_idx;
    logic [c_data_w-1:0] r_work;
    logic [c_data_w-1:0] r_out_data;
    logic                r_out_carry;
    logic [CNT_W-1:0]    r_out_count;
    logic                r_out_short;

    logic                w_accept;
    logic                w_last_slot;
    logic                w_complete;
    logic [c_data_w-1:0] w_merged;

    assign in_ready    = (r_state == c_st_empty) || out_ready;
    assign w_accept    = in_valid && in_ready;
    assign w_last_slot = (r_idx == CNT_W'(NIBBLES - 1));
    assign w_complete  = w_accept && (w_last_slot || in_last);

    // Nibbles below idx come from the working register, the current beat goes
    // at idx, and everything above is forced to zero.
    always_comb begin
        w_merged = '0;
        for (int k = 0; k < NIBBLES; k++) begin
            if (k < int'(r_idx)) begin
                w_merged[k*SUM_W +: SUM_W] = r_work[k*SUM_W +: SUM_W];
            end else if (k == int'(r_idx)) begin
                w_merged[k*SUM_W +: SUM_W] = in_sum;
            end
        end
    end

`ifdef COLLECT_PARITY_EN
    logic r_out_parity;
    assign out_parity = r_out_parity;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_empty;
            r_idx       <= '0;
            r_work      <= '0;
            r_out_data  <= '0;
            r_out_carry <= 1'b0;
            r_out_count <= '0;
            r_out_short <= 1'b0;
`ifdef COLLECT_PARITY_EN
            r_out_parity <= 1'b0;
`endif
        end else begin
            if ((r_state == c_st_full) && out_ready) begin
                r_state <= c_st_empty;
            end
            if (w_complete) begin
                // A completing beat wins over the drain above: a new result
                // loads in the same cycle the old one leaves.
                r_state     <= c_st_full;
                r_out_data  <= w_merged;
                r_out_carry <= in_carry;
                r_out_count <= r_idx + 1'b1;
                r_out_short <= (r_idx < CNT_W'(NIBBLES - 1));
`ifdef COLLECT_PARITY_EN
                r_out_parity <= (^w_merged) ^ in_carry;
`endif
                r_idx       <= '0;
                r_work      <= '0;
            end else if (w_accept) begin
                r_work[r_idx*SUM_W +: SUM_W] <= in_sum;
                r_idx                        <= r_idx + 1'b1;
            end
        end
    end

    assign out_valid = (r_state == c_st_full);
    assign out_data  = r_out_data;
    assign out_carry = r_out_carry;
    assign out_count = r_out_count;
    assign out_short = r_out_short;

endmodule

`default_nettype wire

// File: tb/tb_pipe_result_collector.sv
// ============================================================================
// Module   : tb_pipe_result_collector
// Purpose  : Directed vector table plus a hand-written backpressure sequence
//            for pipe_result_collector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_result_collector;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_sum;
    logic        in_carry;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_carry;
    logic [2:0]  out_count;
    logic        out_short;
`ifdef COLLECT_PARITY_EN
    logic        out_parity;
`endif

    int n_vec;
    int n_bad;

    pipe_result_collector #(.SUM_W(4), .NIBBLES(4), .CNT_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .in_carry  (in_carry),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry),
        .out_count (out_count),
        .out_short (out_short)
`ifdef COLLECT_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        iv;
        logic [3:0]  sum;
        logic        carry;
        logic        last;
        logic        ordy;
        logic        e_rdy;
        logic        e_ov;
        logic        chk;
        logic [15:0] e_data;
        logic        e_carry;
        logic [2:0]  e_cnt;
        logic        e_short;
        logic        e_par;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic iv, input logic [3:0] s,
                       input logic c, input logic l, input logic ordy,
                       input logic erdy, input logic eov, input logic chk,
                       input logic [15:0] ed, input logic ec,
                       input logic [2:0] en, input logic es, input logic ep);
        vec_t v;
        v = '{r, iv, s, c, l, ordy, erdy, eov, chk, ed, ec, en, es, ep};
        tbl.push_back(v);
    endtask

    task automatic check_rdy(input string name, input logic exp);
        n_vec++;
        if (in_ready !== exp) begin
            n_bad++;
            $display("FAIL %s in_ready: got %b want %b", name, in_ready, exp);
        end
    endtask

    task automatic check_out(input string name, input logic eov, input logic chk,
                             input logic [15:0] ed, input logic ec,
                             input logic [2:0] en, input logic es, input logic ep);
        logic ok;
        n_vec++;
        ok = (out_valid === eov);
        if (chk) begin
            ok = ok && (out_data === ed) && (out_carry === ec) &&
                 (out_count === en) && (out_short === es);
`ifdef COLLECT_PARITY_EN
            ok = ok && (out_parity === ep);
`endif
        end
        if (!ok) begin
            n_bad++;
            $display("FAIL %s outputs: got v=%b d=%h c=%b n=%0d s=%b want v=%b d=%h c=%b n=%0d s=%b p=%b",
                     name, out_valid, out_data, out_carry, out_count, out_short,
                     eov, ed, ec, en, es, ep);
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst = 1'b1; in_valid = 1'b0; in_sum = '0; in_carry = 1'b0;
        in_last = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // rst iv sum c l ordy | rdy ov chk data c n s p
        add(1,0,4'h0,0,0,1, 1,0,1,16'h0000,0,0,0,0);
        // full frame
        add(0,1,4'h6,0,0,1, 1,0,0,16'h0000,0,0,0,0);
        add(0,1,4'h3,0,0,1, 1,0,0,16'h0000,0,0,0,0);
        add(0,1,4'hF,1,0,1, 1,0,0,16'h0000,0,0,0,0);
        add(0,1,4'hA,1,1,1, 1,1,1,16'hAF36,1,4,0,1);
        // short frame
        add(0,1,4'h5,0,0,1, 1,0,0,16'h0000,0,0,0,0);
        add(0,1,4'h9,0,1,1, 1,1,1,16'h0095,0,2,1,0);
        // backpressure
        add(0,1,4'h6,0,0,1, 1,0,0,16'h0000,0,0,0,0);
        add(0,1,4'h3,0,0,1, 1,0,0,16'h0000,0,0,0,0);
        add(0,1,4'hF,1,0,1, 1,0,0,16'h0000,0,0,0,0);
        add(0,1,4'hA,1,1,1, 1,1,1,16'hAF36,1,4,0,1);
        for (int i = 0; i < 3; i++)
            add(0,1,4'h7,0,0,0, 0,1,1,16'hAF36,1,4,0,1);
        add(0,0,4'h0,0,0,1, 1,0,0,16'h0000,0,0,0,0);
        add(0,0,4'h0,0,0,1, 1,0,0,16'h0000,0,0,0,0);
        // single beat; idx must still be 0 after the stall
        add(0,1,4'hC,1,1,1, 1,1,1,16'h000C,1,1,1,1);
        // back-to-back, redundant last on the 4th beat
        add(0,1,4'h4,0,0,1, 1,0,0,16'h0000,0,0,0,0);
        add(0,1,4'h3,0,0,1, 1,0,0,16'h0000,0,0,0,0);
        add(0,1,4'h2,0,0,1, 1,0,0,16'h0000,0,0,0,0);
        add(0,1,4'h1,0,1,1, 1,1,1,16'h1234,0,4,0,1);
        add(0,1,4'h8,0,0,1, 1,0,0,16'h0000,0,0,0,0);
        add(0,1,4'h7,0,0,1, 1,0,0,16'h0000,0,0,0,0);
        add(0,1,4'h6,0,0,1, 1,0,0,16'h0000,0,0,0,0);
        add(0,1,4'h5,1,0,1, 1,1,1,16'h5678,1,4,0,1);
        // single-beat frames replacing a draining result in the same cycle
        add(0,1,4'hB,0,1,1, 1,1,1,16'h000B,0,1,1,1);
        add(0,1,4'hD,1,1,1, 1,1,1,16'h000D,1,1,1,0);
        // reset mid-frame, idle gap inside the next frame
        add(0,1,4'h9,0,0,1, 1,0,0,16'h0000,0,0,0,0);
        add(0,1,4'h8,0,0,1, 1,0,0,16'h0000,0,0,0,0);
        add(1,1,4'hE,0,1,1, 1,0,1,16'h0000,0,0,0,0);
        add(0,1,4'h1,0,0,1, 1,0,1,16'h0000,0,0,0,0);
        add(0,1,4'h2,0,0,1, 1,0,1,16'h0000,0,0,0,0);
        add(0,0,4'hF,0,1,1, 1,0,1,16'h0000,0,0,0,0);
        add(0,1,4'h3,0,0,1, 1,0,1,16'h0000,0,0,0,0);
        add(0,1,4'h4,0,0,1, 1,1,1,16'h4321,0,4,0,1);
        add(0,0,4'h0,0,0,1, 1,0,0,16'h0000,0,0,0,0);

        foreach (tbl[i]) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            rst       = tbl[i].rst;
            in_valid  = tbl[i].iv;
            in_sum    = tbl[i].sum;
            in_carry  = tbl[i].carry;
            in_last   = tbl[i].last;
            out_ready = tbl[i].ordy;
            #1;
            check_rdy(nm, tbl[i].e_rdy);
            @(posedge clk);
            #1;
            check_out(nm, tbl[i].e_ov, tbl[i].chk, tbl[i].e_data, tbl[i].e_carry,
                      tbl[i].e_cnt, tbl[i].e_short, tbl[i].e_par);
        end

        // Hand sequence: result held under a longer stall, then drained once
        rst = 1'b0; in_valid = 1'b1; in_sum = 4'h7; in_carry = 1'b0;
        in_last = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        check_out("hold_load", 1'b1, 1'b1, 16'h0007, 1'b0, 3'd1, 1'b1, 1'b1);
        in_sum = 4'h3; in_carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_rdy($sformatf("hold_rdy%0d", i), 1'b0);
            @(posedge clk);
            #1;
            check_out($sformatf("hold%0d", i), 1'b1, 1'b1, 16'h0007, 1'b0, 3'd1, 1'b1, 1'b1);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        check_rdy("drain_rdy", 1'b1);
        @(posedge clk);
        #1;
        check_out("drain", 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
